// File: rtl/conv_window_fetch.sv
// 3x3 window fetcher: raster-scans an image held in a single-port SRAM bank
// and presents zero-padded neighbourhoods over a valid/ready handshake.
module conv_window_fetch #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       sram_en,
    output logic                       sram_wen,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic [DATA_W-1:0]          sram_d,
    input  logic [DATA_W-1:0]          sram_q,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [9*DATA_W-1:0]        win_data,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [3:0]        k;
    logic              pad_d;
    logic              tap_in;
    logic              last_pix;
    int                tap_r;
    int                tap_c;

    assign sram_wen = 1'b1;
    assign sram_d   = '0;
    assign last_pix = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

    // Tap k sits at (row + k/3 - 1, col + k%3 - 1); out-of-image taps are padded.
    always_comb begin
        tap_r     = int'(row) + int'(k) / 3 - 1;
        tap_c     = int'(col) + int'(k) % 3 - 1;
        tap_in    = (tap_r >= 0) && (tap_r < IMG_H) && (tap_c >= 0) && (tap_c < IMG_W);
        sram_en   = 1'b0;
        sram_addr = '0;
        if (state == FETCH && tap_in) begin
            sram_en   = 1'b1;
            sram_addr = ADDR_W'(tap_r * IMG_W + tap_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            k         <= '0;
            pad_d     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            win_valid <= 1'b0;
            win_data  <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is still high only during the done cycle; start is ignored then.
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        row   <= '0;
                        col   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // Read data for tap k-1 arrives now, one cycle after its issue.
                    if (k != 4'd0)
                        win_data[(int'(k) - 1) * DATA_W +: DATA_W] <= pad_d ? '0 : sram_q;
                    pad_d <= !tap_in;
                    k     <= k + 4'd1;
                    if (k == 4'd8)
                        state <= DRAIN;
                end
                DRAIN: begin
                    win_data[8 * DATA_W +: DATA_W] <= pad_d ? '0 : sram_q;
                    win_valid <= 1'b1;
                    win_row   <= row;
                    win_col   <= col;
                    state     <= OUT;
                end
                OUT: begin
                    if (win_valid && win_ready) begin
                        win_valid <= 1'b0;
                        k         <= '0;
                        if (last_pix) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            if (col == COL_W'(IMG_W - 1)) begin
                                col <= '0;
                                row <= row + ROW_W'(1);
                            end else begin
                                col <= col + COL_W'(1);
                            end
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Randomised self-checking bench for conv_window_fetch on a 4x3 image with a
// behavioural SRAM and a neighbourhood reference model.
module tb_conv_window_fetch;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              sram_en;
    logic              sram_wen;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_d;
    logic [DW-1:0]     sram_q;
    logic              win_valid;
    logic              win_ready;
    logic [9*DW-1:0]   win_data;
    logic [1:0]        win_row;
    logic [1:0]        win_col;

    logic [DW-1:0]     mem [W*H];
    int                en_total = 0;
    int                wen_bad  = 0;
    logic [AW-1:0]     addr_log [$];
    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;

    conv_window_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_d(sram_d), .sram_q(sram_q), .win_valid(win_valid),
        .win_ready(win_ready), .win_data(win_data), .win_row(win_row),
        .win_col(win_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            sram_q <= mem[sram_addr];
            en_total++;
            addr_log.push_back(sram_addr);
        end
        if (sram_wen !== 1'b1) wen_bad++;
    end

    task automatic check(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference neighbourhood from the image array with zero padding.
    function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
        logic [9*DW-1:0] v = '0;
        for (int t = 0; t < 9; t++) begin
            int rr = r + t / 3 - 1;
            int cc = c + t % 3 - 1;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) v[t*DW +: DW] = mem[rr*W + cc];
        end
        return v;
    endfunction

    function automatic int exp_en(input int r, input int c);
        int n = 0;
        for (int t = 0; t < 9; t++) begin
            int rr = r + t / 3 - 1;
            int cc = c + t % 3 - 1;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) n++;
        end
        return n;
    endfunction

    function automatic logic [9*DW-1:0] pack9(input int t[9]);
        logic [9*DW-1:0] v = '0;
        for (int i = 0; i < 9; i++) v[i*DW +: DW] = DW'(t[i]);
        return v;
    endfunction

    task automatic check_idle(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
        check({p, "_en"}, sram_en, 0);
        check({p, "_valid"}, win_valid, 0);
        check({p, "_addr"}, sram_addr, 0);
        check({p, "_data"}, win_data, 0);
        check({p, "_row"}, win_row, 0);
        check({p, "_col"}, win_col, 0);
        check({p, "_wen"}, sram_wen, 1);
        check({p, "_d"}, sram_d, 0);
    endtask

    task automatic wait_valid(input string tag);
        int b = 0;
        while (!win_valid && b < 60) begin
            tick();
            b++;
        end
        check(tag, win_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        int b = 0;
        while (!done && b < 60) begin
            tick();
            b++;
        end
        check(tag, done, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic check_window(input string p, input int n, input int base);
        check({p, "_row"}, win_row, n / W);
        check({p, "_col"}, win_col, n % W);
        check({p, "_data"}, win_data, exp_win(n / W, n % W));
        check({p, "_en"}, en_total - base, exp_en(n / W, n % W));
    endtask

    initial begin
        int tp[9];
        int base;
        int abase;
        int bad;
        int dcnt;
        int n;
        int seen;
        int budget;
        bit hs;
        logic [9*DW-1:0] held;

        rst_n = 1'b0;
        start = 1'b0;
        win_ready = 1'b1;
        for (int a = 0; a < W*H; a++) mem[a] = DW'(a);
        #2;
        check_idle("rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Full scan with an ignored mid-scan start and a start in the done cycle.
        pulse_start();
        check("start_busy", busy, 1);
        base = en_total;
        abase = addr_log.size();
        for (int i = 0; i < W*H; i++) begin
            wait_valid("scan_valid");
            if (i == 0) check("first_lat", cyc, 10);
            check_window("scan", i, base);
            if (i == 0) begin
                tp = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
                check("taps_00", win_data, pack9(tp));
                check("addr0", addr_log[abase], 0);
                check("addr1", addr_log[abase+1], 1);
                check("addr2", addr_log[abase+2], 4);
                check("addr3", addr_log[abase+3], 5);
            end
            if (i == 5) begin
                tp = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
                check("taps_11", win_data, pack9(tp));
                check("en_11", en_total - base, 9);
            end
            if (i == 11) begin
                tp = '{6, 7, 0, 10, 11, 0, 0, 0, 0};
                check("taps_23", win_data, pack9(tp));
            end
            base = en_total;
            start = (i == 5);
            tick();
            start = 1'b0;
        end
        wait_done("scan_done");
        check("done_cycle", cyc, 132);
        check("done_busy", busy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_pulse", done, 0);
        check("post_busy", busy, 0);
        tick();
        check("post_busy2", busy, 0);
        check("post_valid", win_valid, 0);
        check("wen_const", wen_bad, 0);

        // Backpressure on (1,2), then reset during FETCH of (2,1).
        pulse_start();
        base = en_total;
        for (int i = 0; i < 9; i++) begin
            wait_valid("bp_valid");
            check_window("bp", i, base);
            if (i == 6) begin
                tp = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
                check("bp_taps", win_data, pack9(tp));
                win_ready = 1'b0;
                held = win_data;
                base = en_total;
                bad = 0;
                repeat (20) begin
                    tick();
                    if (win_valid !== 1'b1 || win_data !== held) bad++;
                end
                check("bp_hold", bad, 0);
                check("bp_no_en", en_total - base, 0);
                win_ready = 1'b1;
            end
            base = en_total;
            tick();
        end
        check("arst_pre_en", sram_en, 1);
        check("arst_pre_addr", sram_addr, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("arst");
        dcnt = 0;
        repeat (3) begin
            tick();
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            if (done || busy) dcnt++;
        end
        check("arst_quiet", dcnt, 0);
        pulse_start();
        base = en_total;
        wait_valid("restart_valid");
        check_window("restart", 0, base);

        // Random image contents and random backpressure.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < W*H; a++) mem[a] = DW'($urandom);
        pulse_start();
        base = en_total;
        n = 0;
        seen = 0;
        bad = 0;
        budget = 2000;
        held = '0;
        while (n < W*H && budget > 0) begin
            if (win_valid) begin
                if (seen == 0) begin
                    check_window("rnd", n, base);
                    base = en_total;
                    held = win_data;
                    seen = 1;
                end else if (win_data !== held) begin
                    bad++;
                end
            end
            win_ready = ($urandom_range(0, 2) != 0);
            hs = win_valid && win_ready;
            tick();
            budget--;
            if (hs) begin
                n++;
                seen = 0;
            end
        end
        check("rnd_count", n, W*H);
        check("rnd_hold", bad, 0);
        wait_done("rnd_done");
        tick();
        check("rnd_idle", busy, 0);
        check("rnd_wen", wen_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Read-side controller for one 8-bit gray-scale image SRAM bank (single port, en/wen/addr/d/q, 1-cycle read latency).
- On start, raster-scans every pixel of an IMG_W x IMG_H image. For each pixel it sequences 9 SRAM reads to assemble the 3x3 neighbourhood, with zero padding at the borders.
- Presents each window to the convolution datapath over a valid/ready handshake.
- Owns the bank's port during a scan; the bank is never written by this block.

Parameters:
- IMG_W, 256, image width in pixels.
- IMG_H, 128, image height in pixels.
- ADDR_W, 15, SRAM address width; IMG_W*IMG_H <= 2**ADDR_W.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a full-image scan; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start through the cycle done is asserted.
- done  out  1  one-cycle pulse after the final window handshake.
- sram_en  out  1  SRAM enable (read issue).
- sram_wen  out  1  SRAM write enable, active-low; constant 1.
- sram_addr  out  ADDR_W  read address = row*IMG_W + col.
- sram_d  out  DATA_W  constant 0.
- sram_q  in  DATA_W  read data, valid the cycle after sram_en=1.
- win_valid  out  1  window available.
- win_ready  in  1  datapath accepts window.
- win_data  out  9*DATA_W  tap k at [k*DATA_W +: DATA_W].
- win_row  out  clog2(IMG_H)  center row of the presented window.
- win_col  out  clog2(IMG_W)  center column of the presented window.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - busy, done, sram_en, win_valid, sram_addr, win_data, win_row and win_col all go to 0.
  - sram_wen stays 1.
  - Reset mid-scan abandons the scan; no done pulse; start is required to restart.
- Tap k (0..8) sits at offset dr = k/3 - 1, dc = k%3 - 1. Tap 0 is top-left, tap 4 is the center, tap 8 is bottom-right.
- States: IDLE, FETCH, DRAIN, OUT.
- IDLE:
  - start=1 clears row, col and the tap counter to 0, then goes to FETCH.
- FETCH (exactly 9 cycles, tap counter k = 0..8):
  - If (row+dr, col+dc) is inside the image: sram_en=1 and sram_addr = (row+dr)*IMG_W + (col+dc).
  - Otherwise: sram_en=0, sram_addr=0, and tap k is marked pad.
  - sram_en and sram_addr are decoded combinationally from the state registers.
  - At each posedge in FETCH cycles 1..8 and in DRAIN, tap k-1 is captured: the value is sram_q, or 0 if that tap was marked pad.
  - The pad flag for the previous tap is delayed one cycle to match the SRAM read latency.
  - After k=8 the state goes to DRAIN.
- DRAIN (1 cycle):
  - sram_en=0 and tap 8 is captured.
  - Then go to OUT with win_valid=1.
- OUT:
  - win_data, win_row and win_col are stable while win_valid=1 and win_ready=0 (backpressure holds indefinitely).
  - On win_valid and win_ready both high: if (row, col) = (IMG_H-1, IMG_W-1), pulse done for 1 cycle, drop busy, and go to IDLE.
  - Otherwise, on the handshake: col wraps to 0 with row+1 when col = IMG_W-1, else col+1; then go to FETCH.
  - win_valid drops in the cycle after the handshake.
- Throughput: 11 cycles per window when win_ready is held at 1.
- Fixed timing: pad taps still take a FETCH cycle.
- The sram_en count per window equals the number of in-bounds taps: 4 at corners, 6 at edges, 9 at interior pixels.
- start during busy has no effect. start in the same cycle done is asserted is ignored.

Test Plan:
- Setup for all scenarios: IMG_W=4, IMG_H=3, SRAM preloaded with mem[a]=a, win_ready tied 1.
- Window (0,0) -> taps {0,0,0,0,0,1,0,4,5}; exactly 4 sram_en pulses; addresses 0,1,4,5 in tap order.
- Window (1,1) -> taps {0,1,2,4,5,6,8,9,10}; 9 sram_en pulses. Window (2,3) -> taps {6,7,0,10,11,0,0,0,0}.
- Full scan from start -> 12 windows in raster order. win_row/win_col sequence runs (0,0)..(0,3),(1,0)..(2,3). done pulses once, 132 cycles after start plus 1. busy is low afterward and sram_wen is 1 throughout.
- Backpressure: win_ready=0 for 20 cycles on window (1,2) -> win_valid and win_data stay {1,2,3,5,6,7,9,10,11}; no sram_en during the stall. Release -> next window (1,3) proceeds.
- Reset: assert rst_n=0 during FETCH of window (2,1) -> all outputs 0 asynchronously; no done. A new start gives (0,0) first. A start pulse mid-scan is ignored, with the window sequence and count unchanged.
